// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM state encoding and counter sizing for the serial adder
package adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_w(8);

endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: combinational 1-bit full adder
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_fsm.sv
// serial_adder_fsm: bit-serial LSB-first adder/subtractor with start/busy/done handshake
module serial_adder_fsm
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state, state_nx;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nx;
    logic             carry, fa_s, fa_co, last_bit, accept;

    full_adder_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign accept   = (state == S_IDLE) && start;
    assign last_bit = bit_cnt == CW'(WIDTH - 1);
    assign res_nx   = WIDTH'({fa_s, res_sh} >> 1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state and handshake outputs; any unused encoding falls back to IDLE
    always_comb begin
        state_nx = (state == S_IDLE) ? (start ? S_RUN : S_IDLE)
                 : (state == S_RUN)  ? (last_bit ? S_DONE : S_RUN)
                 : S_IDLE;
        busy = state == S_RUN;
        done = state == S_DONE;
    end

    // Operand latch, serial step and result capture on the final bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            a_sh    <= a;
            b_sh    <= sub ? ~b : b;
            carry   <= sub | cin;
            bit_cnt <= '0;
        end else if (state == S_RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_nx;
            carry  <= fa_co;
            if (last_bit) begin
                sum  <= res_nx;
                cout <= fa_co;
                ovf  <= carry ^ fa_co;
            end else begin
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_fsm.sv
// tb_serial_adder_fsm: scoreboard bench for WIDTH=8 and WIDTH=1 serial adders
module tb_serial_adder_fsm;

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       v;
        int         cyc;
    } exp_t;

    logic       clk = 0, rst_n = 0;
    logic       start = 0, sub = 0, cin = 0;
    logic [7:0] a = 0, b = 0;
    logic       busy, done, cout, ovf;
    logic [7:0] sum;

    logic       start1 = 0, sub1 = 0, cin1 = 0;
    logic [0:0] a1 = 0, b1 = 0;
    logic       busy1, done1, cout1, ovf1;
    logic [0:0] sum1;

    int   cyc = 0, total = 0, bad = 0;
    exp_t q[$], q1[$];

    serial_adder_fsm #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
        .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    serial_adder_fsm #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .cin(cin1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // WIDTH=8 monitor: result/timing on done, busy run length, output hold while busy
    int         run = 0;
    logic [9:0] held = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            run  = 0;
            held = 0;
        end else begin
            if (busy && done) begin
                total++; bad++;
                $display("FAIL w8_excl busy=%b done=%b required not both high", busy, done);
            end
            if (busy) begin
                run++;
                total++;
                if ({sum, cout, ovf} !== held) begin
                    bad++;
                    $display("FAIL w8_hold got=%h required=%h", {sum, cout, ovf}, held);
                end
            end
            if (done) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL w8_unexpected_done cyc=%0d got sum=%h required no done", cyc, sum);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (sum !== e.s || cout !== e.c || ovf !== e.v || cyc != e.cyc || run != 8) begin
                        bad++;
                        $display("FAIL w8_result got sum=%h cout=%b ovf=%b cyc=%0d run=%0d required sum=%h cout=%b ovf=%b cyc=%0d run=8",
                                 sum, cout, ovf, cyc, run, e.s, e.c, e.v, e.cyc);
                    end
                end
                held = {sum, cout, ovf};
                run  = 0;
            end
        end
    end

    // WIDTH=1 monitor
    always @(negedge clk) begin
        if (rst_n && done1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL w1_unexpected_done cyc=%0d required no done", cyc);
            end else begin
                exp_t e;
                e = q1.pop_front();
                if (sum1 !== e.s[0] || cout1 !== e.c || ovf1 !== e.v || cyc != e.cyc || busy1) begin
                    bad++;
                    $display("FAIL w1_result got sum=%b cout=%b ovf=%b cyc=%0d busy=%b required sum=%b cout=%b ovf=%b cyc=%0d busy=0",
                             sum1, cout1, ovf1, cyc, busy1, e.s[0], e.c, e.v, e.cyc);
                end
            end
        end
    end

    task automatic go(input logic [7:0] ia, ib, input logic isub, icin,
                      input logic [7:0] es, input logic ec, ev);
        @(negedge clk);
        a = ia; b = ib; sub = isub; cin = icin; start = 1;
        q.push_back('{es, ec, ev, cyc + 1 + 8});
        @(negedge clk);
        start = 0;
        a = ~ia; b = ~ib; sub = ~isub; cin = ~icin;
    endtask

    task automatic go1(input logic ia, ib, isub, icin, es, ec, ev);
        @(negedge clk);
        a1 = ia; b1 = ib; sub1 = isub; cin1 = icin; start1 = 1;
        q1.push_back('{{7'd0, es}, ec, ev, cyc + 1 + 1});
        @(negedge clk);
        start1 = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        total++;
        if (q.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout pending8=%0d pending1=%0d required 0", q.size(), q1.size());
            q.delete();
            q1.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, sum, cout, ovf, busy1, done1, sum1, cout1, ovf1} !== '0) begin
            bad++;
            $display("FAIL reset_state got=%b required all zero",
                     {busy, done, sum, cout, ovf, busy1, done1, sum1, cout1, ovf1});
        end
        rst_n = 1;
        go(8'h5A, 8'h3C, 0, 0, 8'h96, 0, 1);  drain();
        go(8'hFF, 8'h00, 0, 1, 8'h00, 1, 0);  drain();
        go(8'h10, 8'h20, 1, 1, 8'hF0, 0, 0);  drain();
        go(8'h80, 8'h01, 1, 0, 8'h7F, 1, 1);  drain();
        go(8'h00, 8'h00, 1, 0, 8'h00, 1, 0);  drain();
        go(8'h80, 8'h80, 0, 0, 8'h00, 1, 1);  drain();
        go(8'h11, 8'h22, 0, 1, 8'h34, 0, 0);  drain();
        // start held through RUN/DONE with operands changed mid-run
        begin
            int c0;
            @(negedge clk);
            c0 = cyc;
            a = 8'h12; b = 8'h34; sub = 0; cin = 0; start = 1;
            q.push_back('{8'h46, 0, 0, c0 + 1 + 8});
            @(negedge clk);
            a = 8'h05; b = 8'h07; sub = 1; cin = 1;
            q.push_back('{8'hFE, 0, 0, c0 + 1 + 8 + 10});
            repeat (8 + 2) @(negedge clk);
            start = 0;
        end
        drain();
        // asynchronous reset mid-run aborts with no done
        @(negedge clk);
        a = 8'h0F; b = 8'h01; sub = 0; cin = 0; start = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 0;
        #1;
        total++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            bad++;
            $display("FAIL async_reset got=%b required all zero", {busy, done, sum, cout, ovf});
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (12) @(negedge clk);
        go(8'h7F, 8'h01, 0, 0, 8'h80, 0, 1);  drain();
        // WIDTH=1 instance
        go1(1, 1, 0, 1, 1, 1, 0);  drain();
        go1(1, 0, 0, 0, 1, 0, 0);  drain();
        go1(0, 1, 1, 0, 1, 0, 1);  drain();
        go1(1, 1, 1, 0, 0, 1, 0);  drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
